// File: rtl/field_pkg.sv
// Shared definitions for the playfield blocks: cell encodings, LFSR seed
// and the rebuild sequencer states.
package field_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SNAKE = 2'b01;
  localparam logic [1:0] CELL_APPLE = 2'b10;
  localparam logic [1:0] CELL_BLOCK = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PAINT,
    COUNT,
    PLACE,
    FIN
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), usable by any
// game block that needs a cheap pseudo-random source.
module lfsr16
  import field_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift left and feed back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // State register, advances every cycle.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/field_builder.sv
// Rebuilds the snake playfield cell map on each step: clears, paints the
// snake, counts empty cells and tops apples back up to N_APPLES.
module field_builder
  import field_pkg::*;
#(
  parameter int SIZE_X   = 10,
  parameter int SIZE_Y   = 10,
  parameter int MAX_LEN  = SIZE_X * SIZE_Y,
  parameter int N_APPLES = 1,
  parameter int RETRIES  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 step,
  input  logic [15:0]                          length,
  input  logic [MAX_LEN*16-1:0]                snake_xy,
  input  logic [SIZE_X*SIZE_Y-1:0]             block_map,
  output logic [2*SIZE_X*SIZE_Y-1:0]           field,
  output logic [$clog2(SIZE_X*SIZE_Y+1)-1:0]   empty_cells,
  output logic [3:0]                           apples,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 ate,
  output logic                                 full
);

  localparam int CELLS = SIZE_X * SIZE_Y;
  localparam int CW    = $clog2(CELLS + 1);
  localparam int FW    = $clog2(2 * CELLS);
  localparam int XW    = $clog2(MAX_LEN * 16);

  state_t              state_q, state_d;
  logic [2*CELLS-1:0]  field_q, field_d, reset_field;
  logic [CW-1:0]       empty_q, empty_d;
  logic [CW-1:0]       scan_q, scan_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [3:0]          apples_q, apples_d;
  logic [15:0]         seg_q, seg_d;
  logic [7:0]          retry_q, retry_d;
  logic                scan_mode_q, scan_mode_d;
  logic                ate_flag_q, ate_flag_d;
  logic                full_q, full_d;

  logic [15:0]         lfsr_out;
  logic [15:0]         len_eff;
  logic [15:0]         seg_xy;
  logic [7:0]          seg_x, seg_y;
  logic                seg_valid;
  logic [CW+7:0]       cell_idx;
  logic [CW-1:0]       rand_idx, place_idx;
  logic [FW-1:0]       paint_pos, count_pos, place_pos;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr_out)
  );

  // Remainder of v by CELLS using restoring shift-and-subtract.
  function automatic logic [CW-1:0] mod_cells(input logic [15:0] v);
    logic [31:0] rem;
    rem = {16'd0, v};
    for (int k = 15; k >= 0; k--) begin
      if (rem >= (32'(CELLS) << k)) rem = rem - (32'(CELLS) << k);
    end
    return CW'(rem);
  endfunction

  // Field pattern after reset: only wall cells are marked.
  always_comb begin
    reset_field = '0;
    for (int k = 0; k < CELLS; k++) begin
      if (block_map[k]) reset_field[2*k +: 2] = CELL_BLOCK;
    end
  end

  // Address generation for the painted segment, the counted cell and the
  // candidate apple cell.
  always_comb begin
    len_eff   = (length > 16'(MAX_LEN)) ? 16'(MAX_LEN) : length;
    seg_xy    = snake_xy[XW'({16'd0, seg_q} << 4) +: 16];
    seg_x     = seg_xy[7:0];
    seg_y     = seg_xy[15:8];
    seg_valid = (32'(seg_x) < 32'(SIZE_X)) && (32'(seg_y) < 32'(SIZE_Y));
    cell_idx  = (CW+8)'(seg_y) * (CW+8)'(SIZE_X) + (CW+8)'(seg_x);
    paint_pos = FW'({cell_idx, 1'b0});
    count_pos = FW'({scan_q, 1'b0});
    rand_idx  = mod_cells(lfsr_out);
    place_idx = scan_mode_q ? ptr_q : rand_idx;
    place_pos = FW'({place_idx, 1'b0});
  end

  // Sequencer next-state and datapath updates for each rebuild phase.
  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    empty_d     = empty_q;
    scan_d      = scan_q;
    ptr_d       = ptr_q;
    apples_d    = apples_q;
    seg_d       = seg_q;
    retry_d     = retry_q;
    scan_mode_d = scan_mode_q;
    ate_flag_d  = ate_flag_q;
    full_d      = full_q;
    case (state_q)
      IDLE: begin
        if (step) state_d = CLEAR;
      end
      CLEAR: begin
        for (int k = 0; k < CELLS; k++) begin
          if (field_q[2*k +: 2] != CELL_APPLE)
            field_d[2*k +: 2] = block_map[k] ? CELL_BLOCK : CELL_EMPTY;
        end
        empty_d     = '0;
        scan_d      = '0;
        seg_d       = '0;
        retry_d     = '0;
        scan_mode_d = 1'b0;
        ate_flag_d  = 1'b0;
        full_d      = 1'b0;
        state_d     = (len_eff == 16'd0) ? COUNT : PAINT;
      end
      PAINT: begin
        if (seg_valid) begin
          if (field_q[paint_pos +: 2] == CELL_APPLE) begin
            apples_d = apples_q - 4'd1;
            if (seg_q == 16'd0) ate_flag_d = 1'b1;
          end
          field_d[paint_pos +: 2] = CELL_SNAKE;
        end
        if (seg_q + 16'd1 >= len_eff) state_d = COUNT;
        else                          seg_d   = seg_q + 16'd1;
      end
      COUNT: begin
        if (field_q[count_pos +: 2] == CELL_EMPTY) empty_d = empty_q + CW'(1);
        if (scan_q == CW'(CELLS - 1))
          state_d = (apples_q >= 4'(N_APPLES)) ? FIN : PLACE;
        else
          scan_d = scan_q + CW'(1);
      end
      PLACE: begin
        if (apples_q >= 4'(N_APPLES)) begin
          state_d = FIN;
        end else if (empty_q == '0) begin
          full_d  = 1'b1;
          state_d = FIN;
        end else if (field_q[place_pos +: 2] == CELL_EMPTY) begin
          field_d[place_pos +: 2] = CELL_APPLE;
          apples_d    = apples_q + 4'd1;
          empty_d     = empty_q - CW'(1);
          retry_d     = '0;
          scan_mode_d = 1'b0;
        end else if (scan_mode_q) begin
          ptr_d = (ptr_q == CW'(CELLS - 1)) ? '0 : ptr_q + CW'(1);
        end else if (retry_q + 8'd1 >= 8'(RETRIES)) begin
          scan_mode_d = 1'b1;
          ptr_d       = (rand_idx == CW'(CELLS - 1)) ? '0 : rand_idx + CW'(1);
        end else begin
          retry_d = retry_q + 8'd1;
        end
      end
      FIN: begin
        state_d = step ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset back to the wall-only field.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      field_q     <= reset_field;
      empty_q     <= '0;
      scan_q      <= '0;
      ptr_q       <= '0;
      apples_q    <= '0;
      seg_q       <= '0;
      retry_q     <= '0;
      scan_mode_q <= 1'b0;
      ate_flag_q  <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      empty_q     <= empty_d;
      scan_q      <= scan_d;
      ptr_q       <= ptr_d;
      apples_q    <= apples_d;
      seg_q       <= seg_d;
      retry_q     <= retry_d;
      scan_mode_q <= scan_mode_d;
      ate_flag_q  <= ate_flag_d;
      full_q      <= full_d;
    end
  end

  assign field       = field_q;
  assign empty_cells = empty_q;
  assign apples      = apples_q;
  assign busy        = (state_q != IDLE) && (state_q != FIN);
  assign done        = (state_q == FIN);
  assign ate         = (state_q == FIN) && ate_flag_q;
  assign full        = full_q;

endmodule
